load_unit: RTL and testbench

- Load path between the data-memory port and the register-file write-back.
- Accepts one decoded load (funct3, effective address, rd) and issues a word-aligned memory read.
- Selects the addressed byte/halfword/word from the returned data and sign- or zero-extends it to DATA_WIDTH.
- Flags misaligned and illegal-funct3 loads without touching memory.
- One load in flight at a time.

---
 rtl/load_unit.sv | 129 ++++++++++++
 tb/tb_load_unit.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/load_unit.sv
// load_unit: single-outstanding load path between the data-memory port and
// register-file write-back. It issues a word-aligned read, then selects and
// extends the addressed byte, halfword or word. Misaligned loads and illegal
// funct3 values raise an exception pulse and never reach memory.
module load_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  ctrl_valid_i,
  output logic                  ctrl_ready_o,
  input  logic [2:0]            ctrl_funct3_i,
  input  logic [ADDR_WIDTH-1:0] ctrl_addr_i,
  input  logic [4:0]            ctrl_rd_i,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic                  wb_valid_o,
  output logic [4:0]            wb_rd_o,
  output logic [DATA_WIDTH-1:0] wb_data_o,
  output logic                  exc_misaligned_o,
  output logic                  exc_illegal_o
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t          state, state_nxt;
  logic [2:0]      f3_q;
  logic [1:0]      off_q;
  logic [4:0]      rd_q;
  logic            accept, illegal, misaligned, launch;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [DATA_WIDTH-1:0] ext_data;

  assign ctrl_ready_o = (state == IDLE);
  assign accept       = ctrl_valid_i && ctrl_ready_o;

  // Classify the incoming request; illegal wins over misaligned
  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (ctrl_funct3_i)
      3'b011, 3'b110, 3'b111: illegal = 1'b1;
      3'b001, 3'b101:         misaligned = ctrl_addr_i[0];
      3'b010:                 misaligned = (ctrl_addr_i[1:0] != 2'b00);
      default:                misaligned = 1'b0;
    endcase
  end

  // Only a legal accepted load ever goes to memory
  assign launch = accept && !illegal && !misaligned;

  // Next-state logic for the IDLE -> REQ -> WAIT load sequence
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (launch)       state_nxt = REQ;
      REQ:     if (mem_gnt_i)    state_nxt = WAIT;
      WAIT:    if (mem_rvalid_i) state_nxt = IDLE;
      default:                   state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state <= IDLE;
    else         state <= state_nxt;
  end

  // Capture request fields and drive the memory request until granted
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      f3_q       <= '0;
      off_q      <= '0;
      rd_q       <= '0;
      mem_req_o  <= 1'b0;
      mem_addr_o <= '0;
    end else begin
      if (accept) begin
        f3_q  <= ctrl_funct3_i;
        off_q <= ctrl_addr_i[1:0];
        rd_q  <= ctrl_rd_i;
      end
      if (launch) begin
        mem_req_o  <= 1'b1;
        mem_addr_o <= {ctrl_addr_i[ADDR_WIDTH-1:2], 2'b00};
      end else if (state == REQ && mem_gnt_i) begin
        mem_req_o  <= 1'b0;
      end
    end
  end

  // Lane select uses the latched offset; the returned word is always aligned
  always_comb begin
    byte_sel = mem_rdata_i[{off_q, 3'b000} +: 8];
    half_sel = mem_rdata_i[{off_q[1], 4'b0000} +: 16];
    case (f3_q)
      3'b000:  ext_data = {{(DATA_WIDTH-8){byte_sel[7]}}, byte_sel};
      3'b100:  ext_data = {{(DATA_WIDTH-8){1'b0}}, byte_sel};
      3'b001:  ext_data = {{(DATA_WIDTH-16){half_sel[15]}}, half_sel};
      3'b101:  ext_data = {{(DATA_WIDTH-16){1'b0}}, half_sel};
      default: ext_data = mem_rdata_i;
    endcase
  end

  // Write-back and exception pulses; wb_rd/wb_data hold until the next load
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wb_valid_o       <= 1'b0;
      wb_rd_o          <= '0;
      wb_data_o        <= '0;
      exc_misaligned_o <= 1'b0;
      exc_illegal_o    <= 1'b0;
    end else begin
      wb_valid_o       <= (state == WAIT) && mem_rvalid_i;
      exc_illegal_o    <= accept && illegal;
      exc_misaligned_o <= accept && !illegal && misaligned;
      if (state == WAIT && mem_rvalid_i) begin
        wb_rd_o   <= rd_q;
        wb_data_o <= ext_data;
      end
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed loads with a scoreboard. Stimulus pushes expected
// write-back/exception events and memory-responder configs into queues; a
// negedge monitor pops and compares whenever the unit presents an output.
module tb_load_unit;

  localparam int KWB = 0, KMIS = 1, KILL = 2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ctrl_valid = 1'b0;
  logic        ctrl_ready;
  logic [2:0]  ctrl_funct3 = '0;
  logic [31:0] ctrl_addr = '0;
  logic [4:0]  ctrl_rd = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_mis, exc_ill;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mem_en = 1'b1;

  typedef struct {
    int          kind;
    logic [4:0]  rd;
    logic [31:0] data;
    int          cyc;
    string       name;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          gdly;
    int          rdly;
    logic [31:0] rdata;
  } mem_t;

  exp_t exp_q[$];
  mem_t mem_q[$];

  load_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) dut (
    .clk_i(clk), .rstn_i(rstn),
    .ctrl_valid_i(ctrl_valid), .ctrl_ready_o(ctrl_ready),
    .ctrl_funct3_i(ctrl_funct3), .ctrl_addr_i(ctrl_addr), .ctrl_rd_i(ctrl_rd),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_gnt_i(mem_gnt),
    .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
    .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
    .exc_misaligned_o(exc_mis), .exc_illegal_o(exc_ill)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic handle(input int kind);
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_event actual_kind=%0d required=none cyc=%0d", kind, cyc);
    end else begin
      e = exp_q.pop_front();
      chk({e.name, "_kind"}, kind, e.kind);
      if (kind == KWB && e.kind == KWB) begin
        chk({e.name, "_rd"}, {27'd0, wb_rd}, {27'd0, e.rd});
        chk({e.name, "_data"}, wb_data, e.data);
      end
      if (e.cyc >= 0) chk({e.name, "_latency"}, cyc - e.cyc, 3);
    end
  endtask

  // Monitor: every output pulse must match the head of the scoreboard
  always @(negedge clk) begin
    if (wb_valid) handle(KWB);
    if (exc_mis)  handle(KMIS);
    if (exc_ill)  handle(KILL);
  end

  // Memory responder: grant after gdly cycles, rvalid rdly cycles after grant
  initial begin
    mem_t m;
    forever begin
      @(negedge clk);
      if (mem_en && mem_req) begin
        if (mem_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mem_req actual=%h required=no_request", mem_addr);
          m = '{addr: mem_addr, gdly: 0, rdly: 1, rdata: 32'h0};
        end else begin
          m = mem_q.pop_front();
        end
        chk("mem_addr", mem_addr, m.addr);
        for (int i = 0; i < m.gdly; i++) begin
          @(negedge clk);
          chk("req_hold", {31'd0, mem_req}, 32'd1);
          chk("addr_hold", mem_addr, m.addr);
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        chk("req_drop", {31'd0, mem_req}, 32'd0);
        for (int i = 1; i < m.rdly; i++) @(negedge clk);
        mem_rvalid = 1'b1;
        mem_rdata  = m.rdata;
        @(negedge clk);
        mem_rvalid = 1'b0;
        mem_rdata  = 32'hA5A5_5A5A;
      end
    end
  end

  task automatic issue(input string name, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [4:0] rd, input int kind, input logic [31:0] data,
                       input logic [31:0] rdata, input int gdly, input int rdly,
                       input bit lat, input bit b2b);
    int n = 0;
    @(negedge clk);
    while (!ctrl_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_ready"}, {31'd0, ctrl_ready}, 32'd1);
    if (b2b) chk({name, "_b2b_in_wb_cycle"}, {31'd0, wb_valid}, 32'd1);
    exp_q.push_back('{kind: kind, rd: rd, data: data, cyc: lat ? cyc : -1, name: name});
    if (kind == KWB)
      mem_q.push_back('{addr: {addr[31:2], 2'b00}, gdly: gdly, rdly: rdly, rdata: rdata});
    ctrl_valid  = 1'b1;
    ctrl_funct3 = f3;
    ctrl_addr   = addr;
    ctrl_rd     = rd;
    @(negedge clk);
    ctrl_valid  = 1'b0;
    if (kind != KWB) chk({name, "_stay_idle"}, {31'd0, ctrl_ready}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1;
    chk("rst_ready", {31'd0, ctrl_ready}, 32'd1);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_exc", {30'd0, exc_mis, exc_ill}, 32'd0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // Byte loads, zero-wait memory, latency checked
    issue("lb_103",  3'b000, 32'h103, 5'd1, KWB, 32'hFFFF_FF80, 32'h80FF_1234, 0, 1, 1, 0);
    drain();
    issue("lbu_103", 3'b100, 32'h103, 5'd2, KWB, 32'h0000_0080, 32'h80FF_1234, 0, 1, 1, 0);
    drain();
    issue("lbu_100", 3'b100, 32'h100, 5'd5, KWB, 32'h0000_0034, 32'h80FF_1234, 0, 1, 0, 0);
    drain();
    // Halfword loads
    issue("lh_202",  3'b001, 32'h202, 5'd6, KWB, 32'hFFFF_8001, 32'h8001_7FFF, 0, 1, 1, 0);
    drain();
    issue("lhu_202", 3'b101, 32'h202, 5'd7, KWB, 32'h0000_8001, 32'h8001_7FFF, 0, 1, 0, 0);
    drain();
    issue("lh_200",  3'b001, 32'h200, 5'd8, KWB, 32'h0000_7FFF, 32'h8001_7FFF, 0, 1, 0, 0);
    drain();
    // Exceptions: no memory traffic, no write-back, wb fields unchanged
    issue("lw_301_mis",  3'b010, 32'h301, 5'd9,  KMIS, 32'h0, 32'h0, 0, 1, 0, 0);
    drain();
    chk("mis_wb_data_held", wb_data, 32'h0000_7FFF);
    issue("lhu_201_mis", 3'b101, 32'h201, 5'd10, KMIS, 32'h0, 32'h0, 0, 1, 0, 0);
    drain();
    issue("f3_011_ill",  3'b011, 32'h300, 5'd11, KILL, 32'h0, 32'h0, 0, 1, 0, 0);
    drain();
    issue("f3_111_ill_prio", 3'b111, 32'h301, 5'd12, KILL, 32'h0, 32'h0, 0, 1, 0, 0);
    drain();
    chk("exc_wb_rd_held", {27'd0, wb_rd}, 32'd8);
    // Delayed grant and delayed rvalid
    issue("lw_400_slow", 3'b010, 32'h400, 5'd17, KWB, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 3, 2, 0, 0);
    drain();
    // Back-to-back: second load accepted in the first load's wb cycle
    issue("lb_501", 3'b000, 32'h501, 5'd3, KWB, 32'hFFFF_FFA5, 32'h0000_A500, 0, 1, 0, 0);
    issue("lb_602", 3'b000, 32'h602, 5'd4, KWB, 32'h0000_007F, 32'h007F_0000, 0, 1, 1, 1);
    drain();

    // Reset while in WAIT, then a stale rvalid after release
    mem_en = 1'b0;
    @(negedge clk);
    ctrl_valid = 1'b1; ctrl_funct3 = 3'b010; ctrl_addr = 32'h500; ctrl_rd = 5'd9;
    @(negedge clk);
    ctrl_valid = 1'b0;
    chk("abort_req_up", {31'd0, mem_req}, 32'd1);
    mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    chk("abort_in_wait", {31'd0, ctrl_ready}, 32'd0);
    rstn = 1'b0;
    #1;
    chk("abort_rst_ready", {31'd0, ctrl_ready}, 32'd1);
    chk("abort_rst_outs", {29'd0, mem_req, wb_valid, exc_mis | exc_ill}, 32'd0);
    chk("abort_rst_wb_data", wb_data, 32'd0);
    chk("abort_rst_wb_rd", {27'd0, wb_rd}, 32'd0);
    chk("abort_rst_addr", mem_addr, 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h1234_5678;
    @(negedge clk);
    mem_rvalid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("post_abort_wb_valid", {31'd0, wb_valid}, 32'd0);
      chk("post_abort_ready", {31'd0, ctrl_ready}, 32'd1);
    end
    chk("post_abort_wb_data", wb_data, 32'd0);
    mem_en = 1'b1;
    chk("mem_q_empty", mem_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
